// File: rtl/registro_banderas_if.sv
// Flag register bus: ALU flag inputs, control strobes, status outputs.
// master = controller side, slave = registro_banderas.
interface registro_banderas_if #(
  parameter int PROFUNDIDAD = 4
);
  localparam int OW = $clog2(PROFUNDIDAD) + 1;

  logic [3:0]    banderas_in;
  logic [2:0]    alu_op;
  logic          cargar;
  logic          guardar;
  logic          restaurar;
  logic          limpiar_sticky;
  logic [2:0]    cond;
  logic [3:0]    banderas_q;
  logic          cond_cumple;
  logic          v_sticky;
  logic          pila_llena;
  logic          pila_vacia;
  logic [OW-1:0] ocupacion;
  logic          error_pila;

  modport master (
    output banderas_in, alu_op, cargar, guardar,
    output restaurar, limpiar_sticky, cond,
    input  banderas_q, cond_cumple, v_sticky,
    input  pila_llena, pila_vacia, ocupacion, error_pila
  );

  modport slave (
    input  banderas_in, alu_op, cargar, guardar,
    input  restaurar, limpiar_sticky, cond,
    output banderas_q, cond_cumple, v_sticky,
    output pila_llena, pila_vacia, ocupacion, error_pila
  );
endinterface

// File: rtl/registro_banderas.sv
// NZCV status register with branch-condition decode and save/restore LIFO.
// Ports: clk, rst (sync, active-high), bus (registro_banderas_if.slave).
module registro_banderas #(
  parameter int PROFUNDIDAD  = 4,
  parameter bit PRESERVAR_CV = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  registro_banderas_if.slave bus
);
  localparam int AW = (PROFUNDIDAD > 1) ? $clog2(PROFUNDIDAD) : 1;
  localparam int OW = $clog2(PROFUNDIDAD) + 1;
  localparam logic [OW-1:0] LLENO = OW'(PROFUNDIDAD);

  logic [3:0]    band_q, band_d;
  logic [OW-1:0] ocup_q, ocup_d;
  logic          sticky_q, sticky_d;
  logic          err_q, err_d;
  logic [3:0]    pila_q [PROFUNDIDAD];

  logic          vacia, llena;
  logic          conflicto, push_ok, pop_ok;
  logic          arit, carga_ev, cc;
  logic [AW-1:0] idx_top, idx_push;

  assign vacia     = (ocup_q == '0);
  assign llena     = (ocup_q == LLENO);
  assign conflicto = bus.guardar & bus.restaurar;
  assign push_ok   = bus.guardar & ~bus.restaurar & ~llena;
  assign pop_ok    = bus.restaurar & ~bus.guardar & ~vacia;
  assign arit      = (bus.alu_op[2:1] == 2'b00);
  assign idx_top   = AW'(ocup_q - OW'(1));
  assign idx_push  = AW'(ocup_q);
  // Any event that writes new flags; cargar is ignored under a valid pop
  assign carga_ev  = pop_ok | bus.cargar;

  always_comb begin
    band_d   = band_q;
    ocup_d   = ocup_q;
    sticky_d = sticky_q;
    err_d    = err_q;
    if (pop_ok) begin
      band_d = pila_q[idx_top];
      ocup_d = ocup_q - OW'(1);
    end else if (bus.cargar) begin
      band_d[3:2] = bus.banderas_in[3:2];
      if (PRESERVAR_CV && !arit)
        band_d[1:0] = band_q[1:0];
      else
        band_d[1:0] = bus.banderas_in[1:0];
    end
    if (push_ok)
      ocup_d = ocup_q + OW'(1);
    if ((bus.guardar & llena) |
        (bus.restaurar & vacia) |
        conflicto)
      err_d = 1'b1;
    // Set beats clear when both happen together
    if (bus.limpiar_sticky)
      sticky_d = 1'b0;
    if (carga_ev && band_d[0])
      sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      band_q   <= '0;
      ocup_q   <= '0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      band_q   <= band_d;
      ocup_q   <= ocup_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
    end
  end

  // Stack storage needs no reset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      pila_q[idx_push] <= band_q;
  end

  always_comb begin
    cc = 1'b1;
    case (bus.cond)
      3'b000: cc = 1'b1;
      3'b001: cc = band_q[2];
      3'b010: cc = ~band_q[2];
      3'b011: cc = band_q[1];
      3'b100: cc = ~band_q[1];
      3'b101: cc = band_q[3];
      3'b110: cc = band_q[0];
      3'b111: cc = (band_q[3] == band_q[0]);
      default: cc = 1'b1;
    endcase
  end

  assign bus.banderas_q  = band_q;
  assign bus.cond_cumple = cc;
  assign bus.v_sticky    = sticky_q;
  assign bus.pila_llena  = llena;
  assign bus.pila_vacia  = vacia;
  assign bus.ocupacion   = ocup_q;
  assign bus.error_pila  = err_q;
endmodule

// File: tb/tb_registro_banderas.sv
// Scoreboard bench for registro_banderas (PRESERVAR_CV=1 and =0).
// Directed vectors, expected values queued, checked by a monitor.
module tb_registro_banderas;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] bi = '0;
  logic [2:0] op = '0;
  logic       c = 0, g = 0, r = 0, l = 0;
  logic [2:0] cd = '0;

  registro_banderas_if #(.PROFUNDIDAD(4)) if0 ();
  registro_banderas_if #(.PROFUNDIDAD(4)) if1 ();

  assign if0.banderas_in = bi;  assign if1.banderas_in = bi;
  assign if0.alu_op = op;       assign if1.alu_op = op;
  assign if0.cargar = c;        assign if1.cargar = c;
  assign if0.guardar = g;       assign if1.guardar = g;
  assign if0.restaurar = r;     assign if1.restaurar = r;
  assign if0.limpiar_sticky = l; assign if1.limpiar_sticky = l;
  assign if0.cond = cd;         assign if1.cond = cd;

  registro_banderas #(.PROFUNDIDAD(4), .PRESERVAR_CV(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  registro_banderas #(.PROFUNDIDAD(4), .PRESERVAR_CV(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    int         dut;
    string      nm;
    logic [3:0] f;
    logic       cc;
    logic       st;
    logic       err;
    logic [2:0] oc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, req);
    end
  endtask

  task automatic step(input logic rs, input logic [3:0] b,
                      input logic [2:0] o, input logic cc_, gg,
                      input logic rr, ll, input logic [2:0] k);
    @(negedge clk); #1;
    rst = rs; bi = b; op = o; c = cc_; g = gg;
    r = rr; l = ll; cd = k;
    @(posedge clk); #1;
  endtask

  task automatic ex(input int d, input string n, input logic [3:0] f,
                    input logic cc_, st, er, input logic [2:0] oc);
    exp_t e;
    e.dut = d; e.nm = n; e.f = f; e.cc = cc_;
    e.st = st; e.err = er; e.oc = oc;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.dut == 0) begin
          chk({e.nm, ".flags"}, int'(if0.banderas_q), int'(e.f));
          chk({e.nm, ".cc"}, int'(if0.cond_cumple), int'(e.cc));
          chk({e.nm, ".sticky"}, int'(if0.v_sticky), int'(e.st));
          chk({e.nm, ".err"}, int'(if0.error_pila), int'(e.err));
          chk({e.nm, ".ocup"}, int'(if0.ocupacion), int'(e.oc));
          chk({e.nm, ".llena"}, int'(if0.pila_llena), int'(e.oc == 3'd4));
          chk({e.nm, ".vacia"}, int'(if0.pila_vacia), int'(e.oc == 3'd0));
        end else begin
          chk({e.nm, ".flags1"}, int'(if1.banderas_q), int'(e.f));
          chk({e.nm, ".cc1"}, int'(if1.cond_cumple), int'(e.cc));
          chk({e.nm, ".sticky1"}, int'(if1.v_sticky), int'(e.st));
          chk({e.nm, ".ocup1"}, int'(if1.ocupacion), int'(e.oc));
        end
      end
    end
  end

  initial begin : stim
    //   rst  bi       op      c  g  r  l  cond
    step(1, 4'b0000, 3'b000, 0, 0, 0, 0, 3'b000);
    ex(0, "reset", 4'b0000, 1, 0, 0, 0);
    ex(1, "reset", 4'b0000, 1, 0, 0, 0);
    step(0, 4'b1001, 3'b000, 1, 0, 0, 0, 3'b111);
    ex(0, "load1001", 4'b1001, 1, 1, 0, 0);
    step(0, 4'b0000, 3'b000, 0, 0, 0, 0, 3'b001);
    ex(0, "condZ", 4'b1001, 0, 1, 0, 0);
    step(0, 4'b0011, 3'b000, 1, 0, 0, 0, 3'b011);
    ex(0, "load0011", 4'b0011, 1, 1, 0, 0);
    ex(1, "load0011", 4'b0011, 1, 1, 0, 0);
    step(0, 4'b0100, 3'b010, 1, 0, 0, 0, 3'b001);
    ex(0, "keepCV", 4'b0111, 1, 1, 0, 0);
    ex(1, "nokeepCV", 4'b0100, 1, 1, 0, 0);
    step(0, 4'b0001, 3'b000, 1, 0, 0, 1, 3'b110);
    ex(0, "setwins", 4'b0001, 1, 1, 0, 0);
    step(0, 4'b0000, 3'b000, 0, 0, 0, 1, 3'b000);
    ex(0, "clear", 4'b0001, 1, 0, 0, 0);
    step(0, 4'b0010, 3'b000, 1, 1, 0, 0, 3'b000);
    ex(0, "push1", 4'b0010, 1, 0, 0, 1);
    step(0, 4'b0100, 3'b000, 1, 1, 0, 0, 3'b000);
    ex(0, "push2", 4'b0100, 1, 0, 0, 2);
    step(0, 4'b1000, 3'b000, 1, 1, 0, 0, 3'b000);
    ex(0, "push3", 4'b1000, 1, 0, 0, 3);
    step(0, 4'b0000, 3'b000, 0, 1, 0, 0, 3'b000);
    ex(0, "push4", 4'b1000, 1, 0, 0, 4);
    step(0, 4'b0000, 3'b000, 0, 1, 0, 0, 3'b000);
    ex(0, "pushfull", 4'b1000, 1, 0, 1, 4);
    step(0, 4'b0000, 3'b000, 0, 0, 1, 0, 3'b000);
    ex(0, "pop1", 4'b1000, 1, 0, 1, 3);
    step(0, 4'b0000, 3'b000, 0, 0, 1, 0, 3'b000);
    ex(0, "pop2", 4'b0100, 1, 0, 1, 2);
    step(0, 4'b0000, 3'b000, 0, 0, 1, 0, 3'b000);
    ex(0, "pop3", 4'b0010, 1, 0, 1, 1);
    step(0, 4'b0000, 3'b000, 0, 0, 1, 0, 3'b000);
    ex(0, "pop4", 4'b0001, 1, 1, 1, 0);
    step(1, 4'b0000, 3'b000, 0, 0, 0, 0, 3'b000);
    ex(0, "reset2", 4'b0000, 1, 0, 0, 0);
    step(0, 4'b0100, 3'b000, 1, 0, 1, 0, 3'b000);
    ex(0, "popempty", 4'b0100, 1, 0, 1, 0);
    step(1, 4'b0000, 3'b000, 0, 0, 0, 0, 3'b000);
    ex(0, "reset3", 4'b0000, 1, 0, 0, 0);
    step(0, 4'b0000, 3'b000, 0, 1, 0, 0, 3'b000);
    ex(0, "push0", 4'b0000, 1, 0, 0, 1);
    step(0, 4'b1100, 3'b011, 1, 1, 1, 0, 3'b001);
    ex(0, "pushpop", 4'b1100, 1, 0, 1, 1);
    step(1, 4'b0000, 3'b000, 0, 0, 0, 0, 3'b000);
    ex(0, "reset4", 4'b0000, 1, 0, 0, 0);
    step(0, 4'b1111, 3'b000, 1, 1, 0, 0, 3'b111);
    ex(0, "ld1111", 4'b1111, 1, 1, 0, 1);
    step(0, 4'b0000, 3'b000, 0, 1, 0, 0, 3'b010);
    ex(0, "condnZ", 4'b1111, 0, 1, 0, 2);
    step(0, 4'b0000, 3'b000, 0, 0, 0, 0, 3'b100);
    ex(0, "condnC", 4'b1111, 0, 1, 0, 2);
    step(0, 4'b0000, 3'b000, 0, 0, 0, 0, 3'b101);
    ex(0, "condN", 4'b1111, 1, 1, 0, 2);
    step(1, 4'b0110, 3'b000, 1, 0, 1, 0, 3'b000);
    ex(0, "midreset", 4'b0000, 1, 0, 0, 0);
    step(0, 4'b0000, 3'b000, 0, 0, 1, 0, 3'b000);
    ex(0, "popafter", 4'b0000, 1, 0, 1, 0);
    step(0, 4'b0000, 3'b000, 0, 0, 0, 0, 3'b000);
    repeat (2) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/registro_banderas.md
Name: registro_banderas

Overview:
- Status register that sits directly downstream of the ALU flag generator.
- Captures the 4-bit flag vector [N,Z,C,V] when the ALU result is committed.
- Holds the flags between instructions and evaluates branch conditions from them.
- Provides a small LIFO so the flags can be saved and restored around interrupts or subroutines.

Parameters:
PROFUNDIDAD, 4, number of entries in the save/restore stack (legal range 2..16).
PRESERVAR_CV, 1, when 1 a non-arithmetic ALU op keeps the previous C and V; when 0 C and V are taken from the input unchanged.

Ports:
clk  input  1  single system clock, rising-edge.
rst  input  1  reset: synchronous, active-high.
banderas_in  input  4  flags from the ALU flag stage: [3]=N, [2]=Z, [1]=C, [0]=V.
alu_op  input  3  opcode of the op that produced banderas_in; 000 = add, 001 = sub, all others non-arithmetic.
cargar  input  1  capture banderas_in this cycle.
guardar  input  1  push current banderas_q onto the stack.
restaurar  input  1  pop the stack top into banderas_q.
limpiar_sticky  input  1  clear v_sticky.
cond  input  3  branch condition select.
banderas_q  output  4  registered flags, same bit order as banderas_in.
cond_cumple  output  1  selected condition is true for banderas_q.
v_sticky  output  1  sticky overflow flag.
pila_llena  output  1  stack holds PROFUNDIDAD entries.
pila_vacia  output  1  stack holds 0 entries.
ocupacion  output  clog2(PROFUNDIDAD)+1  current stack entry count.
error_pila  output  1  sticky stack misuse flag.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset is sampled on the rising edge of clk. It overrides every other input and may be asserted mid-operation.
- Reset values:
  - banderas_q = 0000, v_sticky = 0, error_pila = 0.
  - Stack empty: ocupacion = 0, pila_vacia = 1, pila_llena = 0.
  - Stack contents are don't-care after reset.
- Priority within a cycle: rst > restaurar > cargar.
  - If restaurar and cargar are both asserted, cargar is dropped.
- Capture (cargar = 1, no valid pop this cycle):
  - banderas_q updates on the next edge, giving 1-cycle latency.
  - N and Z always load from banderas_in.
  - If PRESERVAR_CV = 1 and alu_op[2:1] != 00, C and V keep their previous values.
  - Otherwise C and V load from banderas_in.
- v_sticky:
  - Set on the edge where the newly loaded V = 1 (including a V restored by a pop).
  - Cleared by limpiar_sticky.
  - If set and clear occur in the same cycle, set wins.
- Push (guardar = 1, restaurar = 0):
  - Writes the pre-edge banderas_q to the stack and increments ocupacion.
  - A simultaneous cargar still updates banderas_q; the pushed value is the old one.
- Pop (restaurar = 1, guardar = 0):
  - banderas_q takes the top entry on the next edge and ocupacion decrements.
- Push when full: entry discarded, ocupacion unchanged, error_pila set.
- Pop when empty: banderas_q unchanged, but a simultaneous cargar is then honoured; error_pila set.
- guardar and restaurar in the same cycle: stack unchanged, banderas_q follows the cargar rule, error_pila set.
- error_pila clears only on rst.
- Stack flags: pila_llena and pila_vacia are registered-state decodes of ocupacion, with no extra latency.
- cond_cumple is combinational from cond and banderas_q, with zero latency from cond:
  - 000 always true
  - 001 Z
  - 010 ~Z
  - 011 C
  - 100 ~C
  - 101 N
  - 110 V
  - 111 N == V (signed greater-or-equal)
- All stack pointer arithmetic saturates inside 0..PROFUNDIDAD; it never wraps.

Test Plan:
- Reset then cargar with banderas_in=1001, alu_op=000 -> banderas_q=1001 one cycle later, v_sticky=1; cond=111 -> cond_cumple=1; cond=001 -> cond_cumple=0.
- banderas_q=0011, then cargar with banderas_in=0100, alu_op=010, PRESERVAR_CV=1 -> banderas_q=0111; same stimulus with PRESERVAR_CV=0 -> 0100.
- Push four values 0001, 0010, 0100, 1000 (PROFUNDIDAD=4) -> pila_llena=1, ocupacion=4; fifth push -> error_pila=1, ocupacion stays 4; four pops -> banderas_q sequence 1000, 0100, 0010, 0001, then pila_vacia=1.
- Pop on empty stack with cargar=1, banderas_in=0100 -> error_pila=1, banderas_q=0100; guardar+restaurar in the same cycle -> ocupacion unchanged, error_pila=1.
- v_sticky=1 with limpiar_sticky=1 and cargar of V=1 in the same cycle -> v_sticky stays 1; next cycle limpiar_sticky alone -> v_sticky=0.
- rst asserted mid-sequence with ocupacion=2 and banderas_q=1111 -> next edge all outputs at reset values; a subsequent pop -> error_pila=1.
